uart_rx_fifo: RTL and testbench

//  Receive buffer between the UART receiver and the processor. Captures each byte on the

---
 rtl/uart_pkg.sv | 30 +++
 rtl/uart_rx_fifo_if.sv | 23 ++
 rtl/uart_fifo_mem.sv | 34 +++
 rtl/uart_rx_fifo.sv | 113 +++++++++++
 tb/tb_uart_rx_fifo.sv | 197 +++++++++++++++++++
 5 files changed

// File: rtl/uart_pkg.sv
// Shared constants for the UART receive buffer: sizes, timeout length and status-byte layout.
package uart_pkg;

  localparam int dataBits      = 8;
  localparam int fifoDepth     = 16;
  localparam int fifoCntrWidth = 5;
  localparam int timeoutTicks  = 640;
  localparam int ptrWidth      = fifoCntrWidth - 1;
  localparam int tmoWidth      = 10;

  localparam int ST_NEMPTY = 0;
  localparam int ST_HALF   = 1;
  localparam int ST_FULL   = 2;
  localparam int ST_OVR    = 3;
  localparam int ST_TMO    = 4;

  function automatic logic [7:0] pack_status(input logic tmo, input logic ovr,
                                             input logic full, input logic half,
                                             input logic nempty);
    logic [7:0] st;
    st            = 8'h00;
    st[ST_TMO]    = tmo;
    st[ST_OVR]    = ovr;
    st[ST_FULL]   = full;
    st[ST_HALF]   = half;
    st[ST_NEMPTY] = nempty;
    return st;
  endfunction

endpackage

// File: rtl/uart_rx_fifo_if.sv
// Receiver/control-unit side signals of the UART receive buffer, bundled for port connection.
interface uart_rx_fifo_if import uart_pkg::*; ();

  logic                sTick;
  logic                rxDoneTick;
  logic [dataBits-1:0] rxData;
  logic                rdEn;
  logic                statRd;
  logic [dataBits-1:0] dataOut;
  logic [7:0]          statOut;
  logic                rxIrq;

  modport master (
    output sTick, rxDoneTick, rxData, rdEn, statRd,
    input  dataOut, statOut, rxIrq
  );

  modport slave (
    input  sTick, rxDoneTick, rxData, rdEn, statRd,
    output dataOut, statOut, rxIrq
  );

endinterface

// File: rtl/uart_fifo_mem.sv
// FIFO storage: register array with one write port and one registered read port.
// Storage is not reset; only the read register is, so the popped-byte output starts at zero.
module uart_fifo_mem import uart_pkg::*; (
  input  logic                clk,
  input  logic                reset,
  input  logic                we,
  input  logic [ptrWidth-1:0] waddr,
  input  logic [dataBits-1:0] wdata,
  input  logic                re,
  input  logic [ptrWidth-1:0] raddr,
  output logic [dataBits-1:0] rdata
);

  logic [dataBits-1:0] mem_q [fifoDepth];
  logic [dataBits-1:0] rdata_q, rdata_d;

  always_ff @(posedge clk) begin
    if (we) mem_q[waddr] <= wdata;
  end

  // Read sees the pre-write contents, so a full-FIFO push/pop on the same slot pops the old byte.
  always_comb begin
    rdata_d = rdata_q;
    if (re) rdata_d = mem_q[raddr];
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) rdata_q <= '0;
    else        rdata_q <= rdata_d;
  end

  assign rdata = rdata_q;

endmodule

// File: rtl/uart_rx_fifo.sv
// UART receive buffer: 16-deep byte FIFO with status byte, sticky overrun and receive interrupt.
// Optional character timeout is built when UART_RX_TIMEOUT_EN is defined.
module uart_rx_fifo import uart_pkg::*; (
  input logic           clk,
  input logic           reset,
  uart_rx_fifo_if.slave bus
);

  localparam logic [fifoCntrWidth-1:0] CNT_FULL = fifoCntrWidth'(fifoDepth);
  localparam logic [fifoCntrWidth-1:0] CNT_HALF = fifoCntrWidth'(fifoDepth / 2);

  logic [ptrWidth-1:0]      wr_ptr_q, wr_ptr_d;
  logic [ptrWidth-1:0]      rd_ptr_q, rd_ptr_d;
  logic [fifoCntrWidth-1:0] count_q, count_d;
  logic                     overrun_q, overrun_d;
  logic                     rx_timeout;

  logic full, empty, half_full;
  logic push, pop, ovr_set;

  always_comb begin
    full      = (count_q == CNT_FULL);
    empty     = (count_q == '0);
    half_full = (count_q >= CNT_HALF);
    pop       = bus.rdEn & ~empty;
    // A simultaneous pop frees a slot, so a push into a full FIFO is still accepted.
    push      = bus.rxDoneTick & (~full | pop);
    ovr_set   = bus.rxDoneTick & full & ~bus.rdEn;
  end

  always_comb begin
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    count_d   = count_q;
    overrun_d = overrun_q;
    if (push) wr_ptr_d = wr_ptr_q + 1'b1;
    if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
    if (push && !pop)      count_d = count_q + 1'b1;
    else if (pop && !push) count_d = count_q - 1'b1;
    if (ovr_set)         overrun_d = 1'b1;
    else if (bus.statRd) overrun_d = 1'b0;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      count_q   <= '0;
      overrun_q <= 1'b0;
    end else begin
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      count_q   <= count_d;
      overrun_q <= overrun_d;
    end
  end

`ifdef UART_RX_TIMEOUT_EN
  localparam logic [tmoWidth-1:0] TMO_LAST = tmoWidth'(timeoutTicks - 1);

  logic [tmoWidth-1:0] tmo_cnt_q, tmo_cnt_d;
  logic                rx_timeout_q, rx_timeout_d;
  logic                tmo_set;

  // Counter measures idle time with data waiting; it parks at the last value once expired.
  always_comb begin
    tmo_cnt_d    = tmo_cnt_q;
    rx_timeout_d = rx_timeout_q;
    tmo_set      = 1'b0;
    if (push || pop || empty) begin
      tmo_cnt_d = '0;
    end else if (bus.sTick) begin
      if (tmo_cnt_q == TMO_LAST) tmo_set   = 1'b1;
      else                       tmo_cnt_d = tmo_cnt_q + 1'b1;
    end
    if (tmo_set)         rx_timeout_d = 1'b1;
    else if (bus.statRd) rx_timeout_d = 1'b0;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      tmo_cnt_q    <= '0;
      rx_timeout_q <= 1'b0;
    end else begin
      tmo_cnt_q    <= tmo_cnt_d;
      rx_timeout_q <= rx_timeout_d;
    end
  end

  assign rx_timeout = rx_timeout_q;
`else
  logic unused_stick;
  assign unused_stick = bus.sTick;
  assign rx_timeout   = 1'b0;
`endif

  uart_fifo_mem u_mem (
    .clk   (clk),
    .reset (reset),
    .we    (push),
    .waddr (wr_ptr_q),
    .wdata (bus.rxData),
    .re    (pop),
    .raddr (rd_ptr_q),
    .rdata (bus.dataOut)
  );

  always_comb begin
    bus.statOut = pack_status(rx_timeout, overrun_q, full, half_full, ~empty);
    bus.rxIrq   = ~empty | overrun_q | rx_timeout;
  end

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Directed bench for uart_rx_fifo: push/pop ordering, flags, overrun, status clear, timeout, reset.
module tb_uart_rx_fifo;
  import uart_pkg::*;

  logic clk = 1'b0;
  logic reset = 1'b0;
  int   tests = 0;
  int   failed = 0;

  uart_rx_fifo_if bus ();

  uart_rx_fifo dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      failed++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [7:0] b);
    bus.rxDoneTick = 1'b1;
    bus.rxData     = b;
    step();
    bus.rxDoneTick = 1'b0;
  endtask

  task automatic pop();
    bus.rdEn = 1'b1;
    step();
    bus.rdEn = 1'b0;
  endtask

  task automatic ticks(input int n);
    bus.sTick = 1'b1;
    repeat (n) step();
    bus.sTick = 1'b0;
  endtask

  initial begin
    bus.sTick = 1'b0; bus.rxDoneTick = 1'b0; bus.rxData = 8'h00;
    bus.rdEn = 1'b0;  bus.statRd = 1'b0;
    #2;
    check("reset_stat", bus.statOut, 8'h00);
    check("reset_irq",  bus.rxIrq, 1'b0);
    check("reset_data", bus.dataOut, 8'h00);
    repeat (2) step();
    reset = 1'b1;
    step();

    // Test 1: three pushes then three pops in order
    push(8'hA5);
    check("t1_stat_one", bus.statOut, 8'h01);
    check("t1_irq_one",  bus.rxIrq, 1'b1);
    push(8'h3C);
    push(8'hFF);
    check("t1_stat_three", bus.statOut, 8'h01);
    pop();
    check("t1_pop0", bus.dataOut, 8'hA5);
    pop();
    check("t1_pop1", bus.dataOut, 8'h3C);
    pop();
    check("t1_pop2", bus.dataOut, 8'hFF);
    check("t1_stat_empty", bus.statOut, 8'h00);
    check("t1_irq_empty",  bus.rxIrq, 1'b0);

    // Test 4: rdEn on empty FIFO is ignored
    bus.rdEn = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      check("t4_data", bus.dataOut, 8'hFF);
      check("t4_stat", bus.statOut, 8'h00);
      check("t4_irq",  bus.rxIrq, 1'b0);
    end
    bus.rdEn = 1'b0;

    // Test 2: fill, half/full flags, overrun, status clear, set-wins
    for (int i = 0; i < 16; i++) begin
      push(8'(8'h10 + i));
      if (i == 6)  check("t2_below_half", bus.statOut, 8'h01);
      if (i == 7)  check("t2_half",       bus.statOut, 8'h03);
    end
    check("t2_full", bus.statOut, 8'h07);
    push(8'h55);
    check("t2_ovr_stat", bus.statOut, 8'h0F);
    check("t2_ovr_irq",  bus.rxIrq, 1'b1);
    bus.statRd = 1'b1;
    #1;
    check("t2_statrd_preclear", bus.statOut, 8'h0F);
    step();
    bus.statRd = 1'b0;
    check("t2_statrd_cleared", bus.statOut, 8'h07);
    bus.statRd = 1'b1;
    push(8'h56);
    bus.statRd = 1'b0;
    check("t2_set_wins", bus.statOut, 8'h0F);
    bus.statRd = 1'b1;
    step();
    bus.statRd = 1'b0;
    check("t2_cleared_again", bus.statOut, 8'h07);

    // Test 3: push and pop together while full
    bus.rxDoneTick = 1'b1; bus.rxData = 8'hAA; bus.rdEn = 1'b1;
    step();
    bus.rxDoneTick = 1'b0; bus.rdEn = 1'b0;
    check("t3_first_pop", bus.dataOut, 8'h10);
    check("t3_no_ovr",    bus.statOut, 8'h07);
    for (int i = 1; i < 16; i++) begin
      pop();
      check("t3_order", bus.dataOut, 8'(8'h10 + i));
    end
    pop();
    check("t3_last_new", bus.dataOut, 8'hAA);
    check("t3_empty", bus.statOut, 8'h00);
    pop();
    check("t3_no_extra", bus.dataOut, 8'hAA);

    // Test 5: character timeout
`ifdef UART_RX_TIMEOUT_EN
    push(8'h77);
    ticks(639);
    check("t5_not_yet", bus.statOut, 8'h01);
    ticks(1);
    check("t5_timeout", bus.statOut, 8'h11);
    check("t5_irq",     bus.rxIrq, 1'b1);
    bus.statRd = 1'b1;
    step();
    bus.statRd = 1'b0;
    check("t5_cleared", bus.statOut, 8'h01);
    pop();
    check("t5_pop", bus.dataOut, 8'h77);
    push(8'h66);
    push(8'h67);
    ticks(639);
    bus.rdEn = 1'b1; bus.sTick = 1'b1;
    step();
    bus.rdEn = 1'b0; bus.sTick = 1'b0;
    check("t5_pop_prevents", bus.statOut, 8'h01);
    check("t5_pop_data", bus.dataOut, 8'h66);
    ticks(639);
    check("t5_restart_not_yet", bus.statOut, 8'h01);
    ticks(1);
    check("t5_restart_timeout", bus.statOut, 8'h11);
    bus.statRd = 1'b1; bus.rdEn = 1'b1;
    step();
    bus.statRd = 1'b0; bus.rdEn = 1'b0;
    check("t5_final_pop", bus.dataOut, 8'h67);
    check("t5_final_stat", bus.statOut, 8'h00);
`else
    push(8'h77);
    ticks(700);
    check("t5_no_timeout", bus.statOut, 8'h01);
    pop();
    check("t5_pop", bus.dataOut, 8'h77);
    check("t5_empty", bus.statOut, 8'h00);
`endif

    // Test 6: reset mid-transfer
    for (int i = 0; i < 5; i++) push(8'(8'hC0 + i));
    check("t6_queued", bus.statOut, 8'h01);
    bus.rxDoneTick = 1'b1; bus.rxData = 8'h99;
    #2;
    reset = 1'b0;
    #1;
    check("t6_async_stat", bus.statOut, 8'h00);
    check("t6_async_irq",  bus.rxIrq, 1'b0);
    check("t6_async_data", bus.dataOut, 8'h00);
    step();
    step();
    bus.rxDoneTick = 1'b0;
    reset = 1'b1;
    step();
    check("t6_after_stat", bus.statOut, 8'h00);
    pop();
    check("t6_empty_pop", bus.dataOut, 8'h00);
    push(8'h5A);
    pop();
    check("t6_works", bus.dataOut, 8'h5A);
    check("t6_final", bus.statOut, 8'h00);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
